// File: rtl/sbox6_pkg.sv
// Shared types and GF arithmetic for the 6-bit power-map S-box layer.
// The field is GF(2)[x]/(x^6+x^3+1); the tower is GF(4)[y]/(y^3+w) with w^2=w+1.
package sbox6_pkg;

    localparam int WORD_W = 6;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    typedef logic [5:0] word_t;
    // GF(4) element {c1,c0} = c0 + c1*w
    typedef logic [1:0] gf4_t;

    function automatic gf4_t gf4_mul(input gf4_t a, input gf4_t b);
        gf4_t r;
        r[0] = (a[0] & b[0]) ^ (a[1] & b[1]);
        r[1] = (a[0] & b[1]) ^ (a[1] & b[0]) ^ (a[1] & b[1]);
        return r;
    endfunction

    function automatic gf4_t gf4_sq(input gf4_t a);
        return {a[1], a[0] ^ a[1]};
    endfunction

    function automatic gf4_t gf4_mulw(input gf4_t a);
        return {a[0] ^ a[1], a[1]};
    endfunction

    // Tower element packed as {a2,a1,a0} meaning a0 + a1*y + a2*y^2.
    // x has minimal polynomial x^6+x^3+1, so x^(k+3) = w*x^k and the change of
    // basis reduces to a bit permutation: a_k = b_k + w*b_(k+3).
    function automatic word_t to_tower(input word_t b);
        return {b[5], b[2], b[4], b[1], b[3], b[0]};
    endfunction

    function automatic word_t from_tower(input word_t t);
        return {t[5], t[3], t[1], t[4], t[2], t[0]};
    endfunction

    function automatic word_t t_mul(input word_t a, input word_t b);
        gf4_t c0, c1, c2;
        c0 = gf4_mul(a[1:0], b[1:0])
           ^ gf4_mulw(gf4_mul(a[3:2], b[5:4]) ^ gf4_mul(a[5:4], b[3:2]));
        c1 = gf4_mul(a[1:0], b[3:2]) ^ gf4_mul(a[3:2], b[1:0])
           ^ gf4_mulw(gf4_mul(a[5:4], b[5:4]));
        c2 = gf4_mul(a[1:0], b[5:4]) ^ gf4_mul(a[3:2], b[3:2]) ^ gf4_mul(a[5:4], b[1:0]);
        return {c2, c1, c0};
    endfunction

    // Squaring is linear: (a0 + a1 y + a2 y^2)^2 = a0^2 + w a2^2 y + a1^2 y^2
    function automatic word_t t_sq(input word_t a);
        return {gf4_sq(a[3:2]), gf4_mulw(gf4_sq(a[5:4])), gf4_sq(a[1:0])};
    endfunction

endpackage

// File: rtl/sbox6_core.sv
// Combinational S-box core: y = x^34 in GF(2^6), computed in the GF((2^2)^3) tower
// as x^32 * x^2 (five linear squarings and one multiply).
module sbox6_core
    import sbox6_pkg::*;
(
    input  word_t x,
    output word_t y
);

    word_t t1, t2, t4, t8, t16, t32, t34;

    assign t1  = to_tower(x);
    assign t2  = t_sq(t1);
    assign t4  = t_sq(t2);
    assign t8  = t_sq(t4);
    assign t16 = t_sq(t8);
    assign t32 = t_sq(t16);
    assign t34 = t_mul(t32, t2);
    assign y   = from_tower(t34);

endmodule

// File: rtl/sbox6_serial_layer.sv
// Serial S-box layer: substitutes LANES words per beat over NWORDS/LANES beats.
// Define SBOX_PIPE_EN to register core outputs before write-back (adds a DRAIN beat).
module sbox6_serial_layer
    import sbox6_pkg::*;
#(
    parameter int NWORDS = 16,
    parameter int LANES  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORD_W*NWORDS-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_W*NWORDS-1:0] out_data,
    output logic                     busy
);

    localparam int SW    = WORD_W * NWORDS;
    localparam int LW    = WORD_W * LANES;
    localparam int B     = NWORDS / LANES;
    localparam int CNT_W = (B > 1) ? $clog2(B) : 1;

    generate
        if (LANES < 1) begin : g_bad_lanes_zero
            $error("sbox6_serial_layer: LANES must be at least 1");
        end else if ((NWORDS % LANES) != 0) begin : g_bad_lanes_div
            $error("sbox6_serial_layer: LANES must divide NWORDS");
        end
    endgenerate

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high; valid never waits on ready, and only one side is open at a time.
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    shreg_q, shreg_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [LW-1:0]    core_out;
    logic [LW-1:0]    wb;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sbox6_core u_core (
            .x (shreg_q[WORD_W*l +: WORD_W]),
            .y (core_out[WORD_W*l +: WORD_W])
        );
    end

`ifdef SBOX_PIPE_EN
    logic [LW-1:0] pipe_q, pipe_d;
    // The first RUN beat writes back a stale pipe value; it is shifted out by the DRAIN beat.
    assign wb = pipe_q;
`else
    assign wb = core_out;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
`ifdef SBOX_PIPE_EN
        pipe_d      = pipe_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    shreg_d    = in_data;
                    cnt_d      = '0;
                    state_d    = RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            RUN: begin
                shreg_d               = shreg_q >> LW;
                shreg_d[SW-1 -: LW]   = wb;
                cnt_d                 = cnt_q + CNT_W'(1);
`ifdef SBOX_PIPE_EN
                pipe_d                = core_out;
`endif
                if (cnt_q == CNT_W'(B - 1)) begin
                    cnt_d = '0;
`ifdef SBOX_PIPE_EN
                    state_d = DRAIN;
`else
                    state_d     = DONE;
                    out_valid_d = 1'b1;
`endif
                end
            end
            DRAIN: begin
`ifdef SBOX_PIPE_EN
                shreg_d             = shreg_q >> LW;
                shreg_d[SW-1 -: LW] = wb;
                state_d             = DONE;
                out_valid_d         = 1'b1;
`else
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
`endif
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = '0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SBOX_PIPE_EN
            pipe_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef SBOX_PIPE_EN
            pipe_q      <= pipe_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = shreg_q;

endmodule
